invbox_pipe: RTL

- Parametrised, multi-channel successor to the single-bit invertible-pin box used by the integrateinv tests.
- A WIDTH-bit, DEPTH-stage enable-gated register pipeline with per-bit input inversion, enable inversion and output inversion, plus a synchronous flush.
- Carries occupancy tracking: a per-stage valid bit and a count of valid stages.
- Used as the sequential test cell and simulation model for absorbing `$_NOT_` cells into invertible pins on multi-bit and control ports.

---
 rtl/invbox_pkg.sv | 19 +
 rtl/invbox_stage.sv | 45 ++++
 rtl/invbox_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/invbox_pkg.sv
// rtl/invbox_pkg.sv - shared helpers for the invertible-pin register pipeline
package invbox_pkg;

    // Widest data path the inversion helper can carry.
    localparam int INV_MAXW = 64;

    typedef logic [INV_MAXW-1:0] inv_word_t;

    function automatic inv_word_t inv_apply(input inv_word_t value, input inv_word_t mask);
        return value ^ mask;
    endfunction

    function automatic int cnt_w(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/invbox_stage.sv
// rtl/invbox_stage.sv - one pipeline stage: data and valid registers with load/flush
module invbox_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o,
    output logic             vld_next_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // Flush clears occupancy only; the data word is left in place.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            data_d = data_i;
            vld_d  = vld_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o     = data_q;
    assign vld_o      = vld_q;
    assign vld_next_o = vld_d;

endmodule

// File: rtl/invbox_pipe.sv
// rtl/invbox_pipe.sv - enable-gated register pipeline with invertible d/en pins and occupancy count
module invbox_pipe
    import invbox_pkg::*;
#(
    parameter int               WIDTH  = 4,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] INV_D  = '0,
    parameter logic             INV_EN = 1'b0,
    parameter logic [WIDTH-1:0] INV_Y  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    (* invertible_pin = "INV_D" *)
    input  logic [WIDTH-1:0]          d,
    (* invertible_pin = "INV_EN" *)
    input  logic                      en,
    input  logic                      flush,
    output logic [WIDTH-1:0]          y,
    output logic                      valid,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] d_eff;
    logic             en_eff;
    logic [WIDTH-1:0] stage_data_in [DEPTH];
    logic [WIDTH-1:0] stage_data_q  [DEPTH];
    logic [DEPTH-1:0] stage_vld_in;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    count_q, count_d;

    assign d_eff  = WIDTH'(inv_apply(inv_word_t'(d), inv_word_t'(INV_D)));
    assign en_eff = 1'(inv_apply(inv_word_t'(en), inv_word_t'(INV_EN)));

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_data_in[k] = d_eff;
            assign stage_vld_in[k]  = 1'b1;
        end else begin : g_tail
            assign stage_data_in[k] = stage_data_q[k-1];
            assign stage_vld_in[k]  = vld_q[k-1];
        end

        invbox_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .load_i    (en_eff),
            .flush_i   (flush),
            .data_i    (stage_data_in[k]),
            .vld_i     (stage_vld_in[k]),
            .data_o    (stage_data_q[k]),
            .vld_o     (vld_q[k]),
            .vld_next_o(vld_d[k])
        );
    end

    // Counting the next-state vector keeps count aligned with vld in the same cycle.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CW'(vld_d[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign y     = WIDTH'(inv_apply(inv_word_t'(stage_data_q[DEPTH-1]), inv_word_t'(INV_Y)));
    assign valid = vld_q[DEPTH-1];
    assign count = count_q;

endmodule
